// File: rtl/period_meter_pkg.sv
// Shared types and default constants for the period meter slice.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int unsigned  CNT_W_DEF   = 26;
  localparam logic [25:0]  TIMEOUT_DEF = 26'd50000000;

endpackage

// File: rtl/period_meter_if.sv
// Measurement bus of the period meter: enable/pin inputs and result outputs.
interface period_meter_if #(
  parameter int unsigned CNT_W = 26
);
  logic             i_enable;
  logic             i_sig;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high_time;
  logic             o_valid;
  logic             o_timeout;
  logic             o_busy;

  modport master (
    output i_enable, i_sig,
    input  o_period, o_high_time, o_valid, o_timeout, o_busy
  );

  modport slave (
    input  i_enable, i_sig,
    output o_period, o_high_time, o_valid, o_timeout, o_busy
  );
endinterface

// File: rtl/period_meter_sync_edge_det.sv
// Two-flop synchroniser plus history flop; emits single-cycle rise/fall strobes
// for an asynchronous input.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  // NOTE: non-blocking assignments make the three flops shift as a true
  // pipeline; blocking ones would collapse them into a single stage.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign o_rise = sync_q & ~hist_q;
  assign o_fall = ~sync_q & hist_q;

endmodule

// File: rtl/period_meter.sv
// Continuous period / high-time meter for a slow square wave, with a sticky
// stall flag when no rising edge arrives within TIMEOUT cycles.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_DEF)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  period_meter_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TERM = TIMEOUT - ONE;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] high_shadow_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             valid_q;
  logic             timeout_q;
  logic             busy;
  logic             rise;
  logic             fall;
  logic             term;

  sync_edge_det u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (bus.i_sig),
    .o_rise  (rise),
    .o_fall  (fall)
  );

  assign term = (cnt_q == TERM);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d takes a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (!bus.i_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:         state_d = ARM;
        ARM, MEASURE: if (rise)      state_d = MEASURE;
                      else if (term) state_d = ARM;
        default:      state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // A rise on the terminal-count cycle is a legal measurement, so it is
  // tested before the timeout.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q         <= '0;
      high_shadow_q <= '0;
      period_q      <= '0;
      high_q        <= '0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.i_enable || state_q == IDLE) begin
        cnt_q <= '0;
      end else if (rise) begin
        cnt_q <= '0;
        if (state_q == MEASURE) begin
          period_q  <= cnt_q + ONE;
          high_q    <= high_shadow_q;
          valid_q   <= 1'b1;
          timeout_q <= 1'b0;
        end
      end else if (term) begin
        cnt_q     <= '0;
        period_q  <= '0;
        high_q    <= '0;
        timeout_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + ONE;
        if (fall && state_q == MEASURE) high_shadow_q <= cnt_q + ONE;
      end
    end
  end

  assign bus.o_period    = period_q;
  assign bus.o_high_time = high_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_timeout   = timeout_q;
  assign bus.o_busy      = busy;

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period and high time, in i_clk cycles, of a slow square wave on a single input pin.
- It is the receiving end of the team's divided-clock/toggle generators. It checks or calibrates a generated frequency output, or measures an external square wave.
- It sits in the practice/ALU sandbox next to the timer generators and feeds a status display or a self-check.

Parameters:
- CNT_W, 26, width of the cycle counter and of the o_period/o_high_time outputs.
- TIMEOUT, 26'd50000000, cycle count with no rising edge after which the input is declared stalled. Legal range 2 to 2^CNT_W-1.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous active-high reset
- i_enable  input  1  measurement enable (synchronous level)
- i_sig  input  1  asynchronous square wave under measurement
- o_period  output  CNT_W  last measured period in i_clk cycles
- o_high_time  output  CNT_W  last measured high time in i_clk cycles
- o_valid  output  1  one-cycle pulse when o_period/o_high_time update
- o_timeout  output  1  sticky stall flag
- o_busy  output  1  high while not in IDLE

Behaviour:
- Interface (already decided): one clock, i_clk. Reset i_reset is asynchronous and active-high. All registers clear on i_reset.
- Reset values:
  - o_period=0, o_high_time=0
  - o_valid=0, o_timeout=0, o_busy=0
  - FSM=IDLE, counters=0, synchroniser flops=0
- Input conditioning:
  - i_sig passes through a 2-flop synchroniser, then one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - A rising edge at the pin is detected 2-3 cycles later. The constant latency cancels in period measurement.
- FSM states: IDLE, ARM, MEASURE.
- IDLE:
  - Counters held at 0.
  - i_enable=1 -> ARM on the next cycle.
- ARM:
  - Waits for rise; the counter runs for timeout purposes.
  - On rise: cnt<=0, go to MEASURE.
- MEASURE:
  - cnt increments by 1 every cycle.
  - On fall: high_shadow <= cnt+1.
  - On rise: o_period <= cnt+1, o_high_time <= high_shadow, o_valid=1 on the following cycle, o_timeout<=0, cnt<=0. Stay in MEASURE, so measurement is continuous.
  - A square wave of P cycles therefore reports o_period=P, with the first result after two rising edges.
- Timeout:
  - In ARM or MEASURE, if cnt reaches TIMEOUT-1 with no rise that cycle: o_timeout<=1, o_period<=0, o_high_time<=0, cnt<=0, go to ARM. No o_valid pulse.
  - rise on the same cycle as the terminal count wins: the measurement is taken and no timeout occurs.
  - cnt never wraps, because TIMEOUT ≤ 2^CNT_W-1.
- o_timeout clears only on the next valid measurement or on reset.
- i_enable=0 in any state: go to IDLE next cycle, cnt cleared, no o_valid. o_period, o_high_time and o_timeout hold their values.
- Re-enable always restarts from ARM; a partial period is never reported.
- A rise and fall cannot occur on the same cycle. A fall seen in ARM is ignored.
- o_busy = (state != IDLE).
- Asynchronous reset mid-measurement returns every output to its reset value immediately.

Decomposition:
- Shared package, period_meter_pkg:
  - state enum {IDLE, ARM, MEASURE} (2 bits)
  - default CNT_W and TIMEOUT constants
- Sub-module sync_edge_det: 2-flop synchroniser plus history flop, with outputs rise/fall.
  - It is reusable for button and other asynchronous inputs across the codebase.

Test Plan:
- Reset: assert i_reset mid-MEASURE -> all outputs read 0 within the same cycle (no clock edge needed); o_busy=0.
- Steady wave: TIMEOUT=100, i_enable=1, i_sig toggling every 5 cycles -> first o_valid after the second rise, o_period=10, o_high_time=5. o_valid repeats every 10 cycles with the same values.
- Duty cycle: i_sig high 3 cycles, low 9 cycles -> o_period=12, o_high_time=3 on every o_valid.
- Stall: TIMEOUT=100, wave stops high after a valid measurement -> o_timeout=1 and o_period=0 exactly 100 cycles after the last cnt clear. Then restart toggling every 5 cycles -> o_timeout returns to 0 on the next o_valid with o_period=10.
- Enable drop: deassert i_enable mid-period -> IDLE next cycle, no o_valid, outputs hold their last values. Re-enable -> the next result needs two rises and reports 10.
- Boundary: period exactly TIMEOUT (rise coincides with terminal count) -> o_valid with o_period=TIMEOUT, o_timeout stays 0.
